// File: rtl/snake_dir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// snake_dir_ctrl_pkg : headings, run states and heading helpers for the
//                      snake direction controller.
// Revision: 1.0
// ============================================================================
package snake_dir_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Headings are numbered clockwise, so a turn is a modulo-4 step.
    function automatic logic [1:0] turn_ccw(input logic [1:0] d);
        return d - 2'd1;
    endfunction

    function automatic logic [1:0] turn_cw(input logic [1:0] d);
        return d + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_ctrl_turn_queue.sv
`default_nettype none
// ============================================================================
// snake_dir_ctrl_turn_queue : small FIFO of pending headings; a push and a
//                             pop in the same cycle are both honoured.
// Revision: 1.0
// ============================================================================
module snake_dir_ctrl_turn_queue
    import snake_dir_ctrl_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [1:0] push_dir_i,
    input  logic       pop_i,
    output logic [1:0] head_o,
    output logic [1:0] tail_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [1:0]    mem_q [QDEPTH];
    logic [1:0]    mem_d [QDEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(QDEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A full queue still takes a push when its head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = mem_q[0];

    always_comb begin
        tail_o = mem_q[0];
        for (int i = 0; i < QDEPTH; i++) begin
            if (count_q == CW'(i + 1)) tail_o = mem_q[i];
        end
    end

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (pop_ok) begin
            for (int i = 0; i < QDEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
            count_d = count_q - CW'(1);
        end
        if (push_ok) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (count_d == CW'(i)) mem_d[i] = push_dir_i;
            end
            count_d = count_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= DIR_UP;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// snake_dir_ctrl : game run-state FSM, snake heading with buffered turns,
//                  speed level and move-tick generation.
// Revision: 1.0
// ============================================================================
module snake_dir_ctrl
    import snake_dir_ctrl_pkg::*;
#(
    parameter int TICK_BASE = 25_000_000,
    parameter int CNT_W     = 25,
    parameter int QDEPTH    = 2
) (
    input  logic       clk_crystal,
    input  logic       rst_global,
    input  logic       kb_up,
    input  logic       kb_down,
    input  logic       kb_left,
    input  logic       kb_right,
    input  logic       BTNC_d_o,
    input  logic       BTNL_d_o,
    input  logic       BTNR_d_o,
    input  logic       BTNU_d_o,
    input  logic       game_over_i,
    output logic [1:0] dir_o,
    output logic       move_tick_o,
    output logic [1:0] state_o,
    output logic [1:0] speed_o
);

    state_e           state_q;
    logic [1:0]       dir_q;
    logic             tick_q;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       q_head, q_tail, ref_dir, req_dir;
    logic             q_empty, q_full;
    logic             req_valid, req_abs, req_ok;
    logic             tick_due, q_push, q_clr;
    logic [CNT_W-1:0] period_lim;

    // New turns chain off the last queued heading, not the one on screen.
    assign ref_dir = q_empty ? dir_q : q_tail;

    always_comb begin
        req_valid = 1'b1;
        req_abs   = 1'b1;
        req_dir   = DIR_UP;
        if (kb_up) begin
            req_dir = DIR_UP;
        end else if (kb_down) begin
            req_dir = DIR_DOWN;
        end else if (kb_left) begin
            req_dir = DIR_LEFT;
        end else if (kb_right) begin
            req_dir = DIR_RIGHT;
        end else if (BTNL_d_o) begin
            req_abs = 1'b0;
            req_dir = turn_ccw(ref_dir);
        end else if (BTNR_d_o) begin
            req_abs = 1'b0;
            req_dir = turn_cw(ref_dir);
        end else begin
            req_valid = 1'b0;
            req_abs   = 1'b0;
        end
    end

    assign req_ok     = req_valid && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'd2));
    assign period_lim = CNT_W'((TICK_BASE >> speed_q) - 1);
    assign tick_due   = (state_q == ST_RUN) && !game_over_i && !BTNC_d_o && (cnt_q >= period_lim);
    assign q_push     = (state_q == ST_RUN) && req_ok;
    assign q_clr      = (state_q == ST_OVER) && BTNC_d_o;

    snake_dir_ctrl_turn_queue #(
        .QDEPTH (QDEPTH)
    ) u_turn_queue (
        .clk        (clk_crystal),
        .rst        (rst_global),
        .clr_i      (q_clr),
        .push_i     (q_push),
        .push_dir_i (req_dir),
        .pop_i      (tick_due),
        .head_o     (q_head),
        .tail_o     (q_tail),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    always_ff @(posedge clk_crystal) begin
        if (rst_global) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            tick_q  <= 1'b0;
            speed_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            tick_q <= 1'b0;
            if (BTNU_d_o) speed_q <= speed_q + 2'd1;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_abs) dir_q <= req_dir;
                    if (BTNC_d_o) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (game_over_i) begin
                        state_q <= ST_OVER;
                    end else if (BTNC_d_o) begin
                        state_q <= ST_PAUSE;
                    end else if (tick_due) begin
                        cnt_q  <= '0;
                        tick_q <= 1'b1;
                        if (!q_empty) dir_q <= q_head;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (BTNC_d_o) state_q <= ST_RUN;
                end
                ST_OVER: begin
                    if (BTNC_d_o) begin
                        state_q <= ST_IDLE;
                        dir_q   <= DIR_RIGHT;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dir_o       = dir_q;
    assign move_tick_o = tick_q;
    assign state_o     = state_q;
    assign speed_o     = speed_q;

    logic unused_ok;
    assign unused_ok = q_full;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// tb_snake_dir_ctrl : directed scenarios plus randomized pulses checked
//                     against a queue-based behavioural model.
// Revision: 1.0
// ============================================================================
module tb_snake_dir_ctrl;

    localparam int TB_TICK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic kb_up = 0, kb_down = 0, kb_left = 0, kb_right = 0;
    logic btnc = 0, btnl = 0, btnr = 0, btnu = 0, go = 0;
    logic [1:0] dir, state, speed;
    logic tick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state, m_dir, m_speed, m_cnt;
    bit m_tick;
    int m_q[$];

    snake_dir_ctrl #(
        .TICK_BASE (TB_TICK),
        .CNT_W     (5),
        .QDEPTH    (2)
    ) dut (
        .clk_crystal (clk),
        .rst_global  (rst),
        .kb_up       (kb_up),
        .kb_down     (kb_down),
        .kb_left     (kb_left),
        .kb_right    (kb_right),
        .BTNC_d_o    (btnc),
        .BTNL_d_o    (btnl),
        .BTNR_d_o    (btnr),
        .BTNU_d_o    (btnu),
        .game_over_i (go),
        .dir_o       (dir),
        .move_tick_o (tick),
        .state_o     (state),
        .speed_o     (speed)
    );

    task automatic model_update();
        int  req, ref_h;
        bit  is_abs, tk, okreq, popping, room;
        if (rst) begin
            m_state = 0; m_dir = 1; m_tick = 0; m_speed = 0; m_cnt = 0;
            m_q.delete();
            return;
        end
        ref_h = (m_q.size() > 0) ? m_q[$] : m_dir;
        req = -1; is_abs = 1;
        if (kb_up)         req = 0;
        else if (kb_down)  req = 2;
        else if (kb_left)  req = 3;
        else if (kb_right) req = 1;
        else if (btnl) begin req = (ref_h + 3) % 4; is_abs = 0; end
        else if (btnr) begin req = (ref_h + 1) % 4; is_abs = 0; end
        tk = 0;
        case (m_state)
            0: begin
                if (req >= 0 && is_abs) m_dir = req;
                if (btnc) begin m_state = 1; m_cnt = 0; end
            end
            1: begin
                if (go) m_state = 3;
                else if (btnc) m_state = 2;
                else if (m_cnt >= (TB_TICK >> m_speed) - 1) begin tk = 1; m_cnt = 0; end
                else m_cnt++;
                okreq   = (req >= 0) && (req != ref_h) && (req != (ref_h ^ 2));
                popping = tk && (m_q.size() > 0);
                room    = (m_q.size() < 2) || popping;
                if (popping) m_dir = m_q.pop_front();
                if (okreq && room) m_q.push_back(req);
            end
            2: if (btnc) m_state = 1;
            default: if (btnc) begin m_state = 0; m_q.delete(); m_dir = 1; m_cnt = 0; end
        endcase
        m_tick = tk;
        if (btnu) m_speed = (m_speed + 1) % 4;
    endtask

    task automatic clear_pulses();
        kb_up = 0; kb_down = 0; kb_left = 0; kb_right = 0;
        btnc = 0; btnl = 0; btnr = 0; btnu = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        clear_pulses();
    endtask

    // Steps until a move tick is seen; n is the step count, or -1 on timeout.
    task automatic wait_tick(output int n);
        bit seen = 0;
        n = 0;
        while (!seen && n < 300) begin
            step();
            n++;
            if (tick === 1'b1) seen = 1;
        end
        if (!seen) n = -1;
    endtask

    task automatic start_run();
        int n;
        go = 0; rst = 1;
        step(); step();
        rst = 0; btnc = 1;
        step();
        wait_tick(n);
    endtask

    task automatic test_reset();
        rst = 1; kb_up = 1; btnc = 1; btnu = 1;
        step();
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL reset_dir: got %0d expected 1", dir); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", tick); end
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        rst = 0;
        step();
        checks++; if (tick !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL post_reset: tick=%0d state=%0d expected 0/0", tick, state); end
    endtask

    task automatic test_start();
        int n, ticks;
        kb_down = 1; step();
        checks++; if (dir !== 2'd2) begin errors++; $display("FAIL idle_kb_down: got %0d expected 2", dir); end
        kb_right = 1; step();
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL idle_kb_right: got %0d expected 1", dir); end
        ticks = 0;
        repeat (20) begin step(); if (tick !== 1'b0) ticks++; end
        checks++; if (ticks != 0) begin errors++; $display("FAIL idle_no_tick: got %0d ticks expected 0", ticks); end
        btnc = 1; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
        wait_tick(n);
        checks++; if (n != 16) begin errors++; $display("FAIL first_tick_delay: got %0d expected 16", n); end
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL first_tick_dir: got %0d expected 1", dir); end
    endtask

    task automatic test_queue_order();
        int n;
        kb_up = 1; step();
        kb_left = 1; step();
        wait_tick(n);
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL queue_tick1: got %0d expected 0", dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL queue_tick2: got %0d expected 3", dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd3 || n != 16) begin errors++; $display("FAIL queue_tick3: dir=%0d gap=%0d expected 3/16", dir, n); end
    endtask

    task automatic test_reject();
        int n;
        start_run();
        kb_left = 1; step();
        kb_right = 1; step();
        wait_tick(n);
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL reject_same_rev: got %0d expected 1", dir); end
        btnr = 1; step();
        wait_tick(n);
        checks++; if (dir !== 2'd2) begin errors++; $display("FAIL relative_right: got %0d expected 2", dir); end
        btnl = 1; step();
        wait_tick(n);
        checks++; if (dir !== 2'd1) begin errors++; $display("FAIL relative_left: got %0d expected 1", dir); end
    endtask

    task automatic test_queue_full();
        int n;
        start_run();
        kb_up = 1; step();
        kb_left = 1; step();
        kb_down = 1; step();
        wait_tick(n);
        checks++; if (dir !== 2'd0) begin errors++; $display("FAIL full_tick1: got %0d expected 0", dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL full_tick2: got %0d expected 3", dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL full_drop: got %0d expected 3", dir); end
        kb_up = 1; step();
        kb_left = 1; step();
        repeat (13) step();
        kb_down = 1; step();
        checks++; if (tick !== 1'b1 || dir !== 2'd0) begin errors++; $display("FAIL push_pop_tick: tick=%0d dir=%0d expected 1/0", tick, dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd3) begin errors++; $display("FAIL push_pop_next: got %0d expected 3", dir); end
        wait_tick(n);
        checks++; if (dir !== 2'd2) begin errors++; $display("FAIL push_pop_landed: got %0d expected 2", dir); end
    endtask

    task automatic test_pause_over();
        int n, ticks;
        start_run();
        repeat (5) step();
        btnc = 1; step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d expected 2", state); end
        ticks = 0;
        repeat (100) begin kb_up = 1; step(); if (tick !== 1'b0) ticks++; end
        checks++; if (ticks != 0 || state !== 2'd2) begin errors++; $display("FAIL pause_hold: ticks=%0d state=%0d expected 0/2", ticks, state); end
        btnc = 1; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d expected 1", state); end
        wait_tick(n);
        checks++; if (n != 11 || dir !== 2'd1) begin errors++; $display("FAIL resume_tick: gap=%0d dir=%0d expected 11/1", n, dir); end
        kb_up = 1; step();
        go = 1; btnc = 1; step();
        checks++; if (state !== 2'd3 || tick !== 1'b0) begin errors++; $display("FAIL over_prio: state=%0d tick=%0d expected 3/0", state, tick); end
        kb_left = 1; step();
        go = 0;
        btnc = 1; step();
        checks++; if (state !== 2'd0 || dir !== 2'd1) begin errors++; $display("FAIL over_to_idle: state=%0d dir=%0d expected 0/1", state, dir); end
        btnc = 1; step();
        wait_tick(n);
        checks++; if (n != 16 || dir !== 2'd1) begin errors++; $display("FAIL queue_cleared: gap=%0d dir=%0d expected 16/1", n, dir); end
    endtask

    task automatic test_speed();
        int n;
        start_run();
        btnu = 1; step();
        btnu = 1; step();
        checks++; if (speed !== 2'd2) begin errors++; $display("FAIL speed_two: got %0d expected 2", speed); end
        wait_tick(n);
        wait_tick(n);
        checks++; if (n != 4) begin errors++; $display("FAIL period_speed2: got %0d expected 4", n); end
        btnu = 1; step();
        btnu = 1; step();
        checks++; if (speed !== 2'd0) begin errors++; $display("FAIL speed_wrap: got %0d expected 0", speed); end
        wait_tick(n);
        wait_tick(n);
        checks++; if (n != 16) begin errors++; $display("FAIL period_speed0: got %0d expected 16", n); end
        repeat (10) step();
        btnu = 1; step();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL shrink_early: got %0d expected 0", tick); end
        step();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL shrink_tick: got %0d expected 1", tick); end
    endtask

    task automatic test_random();
        int bad = 0;
        go = 0; rst = 1; step(); rst = 0;
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) go = ~go;
            kb_up    = ($urandom_range(0, 11) == 0);
            kb_down  = ($urandom_range(0, 11) == 0);
            kb_left  = ($urandom_range(0, 11) == 0);
            kb_right = ($urandom_range(0, 11) == 0);
            btnl     = ($urandom_range(0, 9) == 0);
            btnr     = ($urandom_range(0, 9) == 0);
            btnc     = ($urandom_range(0, 39) == 0);
            btnu     = ($urandom_range(0, 59) == 0);
            step();
            checks++;
            if (state !== 2'(m_state) || dir !== 2'(m_dir) || tick !== m_tick || speed !== 2'(m_speed)) begin
                errors++;
                if (bad < 10) $display("FAIL random_cycle%0d: got st=%0d dir=%0d tick=%0d spd=%0d expected st=%0d dir=%0d tick=%0d spd=%0d",
                                       i, state, dir, tick, speed, m_state, m_dir, m_tick, m_speed);
                bad++;
            end
        end
        rst = 0; go = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_queue_order();
        test_reject();
        test_queue_full();
        test_pause_over();
        test_speed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
